// File: rtl/mil_spi_hub_pkg.sv
// Shared types for the MIL/SPI command hub.
// Command codes, hub states and the per-command datapath enables.
package mil_spi_hub_pkg;

  typedef enum logic [2:0] {
    TCC_UNKNOWN      = 3'd0,
    TCC_SEND_DATA    = 3'd1,
    TCC_RECEIVE_STS  = 3'd2,
    TCC_RECEIVE_DATA = 3'd3,
    TCC_RESET        = 3'd4
  } TCommandCode;

  typedef enum logic [2:0] {
    HS_IDLE,
    HS_SEND,
    HS_RECV_STS,
    HS_RECV_DATA,
    HS_RESET
  } THubState;

  typedef struct packed {
    THubState state;
    logic     spiPush;
    logic     popSts;
    logic     popData;
    logic     rstReq;
  } THubCfg;

  function automatic THubCfg hub_cfg(
    input TCommandCode code
  );
    THubCfg c;
    c = '0;
    c.state = HS_IDLE;
    case (code)
      TCC_SEND_DATA: begin
        c.state   = HS_SEND;
        c.spiPush = 1'b1;
      end
      TCC_RECEIVE_STS: begin
        c.state  = HS_RECV_STS;
        c.popSts = 1'b1;
      end
      TCC_RECEIVE_DATA: begin
        c.state   = HS_RECV_DATA;
        c.popData = 1'b1;
      end
      TCC_RESET: begin
        c.state  = HS_RESET;
        c.rstReq = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mil_spi_status_ser.sv
// Status word serialiser: buffer-fill snapshot streamed ms0,sm0,ms1,...
// MILSPI_TIMEOUT_EN adds the sticky watchdog flag in bit SIZE_W-1 of word 0.
module mil_spi_status_ser
  import mil_spi_hub_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SIZE_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       snap,
  input  logic                       active,
`ifdef MILSPI_TIMEOUT_EN
  input  logic                       tsSet,
`endif
  input  logic [CHANNELS*SIZE_W-1:0] memUsedMs,
  input  logic [CHANNELS*SIZE_W-1:0] memUsedSm,
  input  logic                       statPop,
  output logic                       statRdy,
  output logic [SIZE_W-1:0]          statData
);

  localparam int NW = 2 * CHANNELS;
  localparam int IW = $clog2(NW + 1);

  logic [SIZE_W-1:0] words [NW];
  logic [IW-1:0]     idx;

  assign statRdy = active && (idx < IW'(NW));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) words[i] <= '0;
      idx <= '0;
    end else if (snap) begin
      for (int i = 0; i < CHANNELS; i++) begin
        words[2*i]   <= memUsedMs[i*SIZE_W +: SIZE_W];
        words[2*i+1] <= memUsedSm[i*SIZE_W +: SIZE_W];
      end
      idx <= '0;
    end else if (statRdy && statPop) begin
      idx <= idx + IW'(1);
    end
  end

`ifdef MILSPI_TIMEOUT_EN
  logic tsFlag;

  always_ff @(posedge clk) begin
    if (rst || snap) tsFlag <= 1'b0;
    else if (tsSet)  tsFlag <= 1'b1;
  end
`endif

  always_comb begin
    statData = '0;
    for (int i = 0; i < NW; i++)
      if (idx == IW'(i)) statData = words[i];
`ifdef MILSPI_TIMEOUT_EN
    if (idx == '0 && tsFlag) statData[SIZE_W-1] = 1'b1;
`endif
  end

endmodule

// File: rtl/mil_spi_hub.sv
// Command dispatcher between the SPI link and CHANNELS MIL links.
// Optional command watchdog: define MILSPI_TIMEOUT_EN.
module mil_spi_hub
  import mil_spi_hub_pkg::*;
#(
  parameter int         CHANNELS       = 2,
  parameter logic [7:0] SPI_BLOCK_ADDR = 8'hAB,
  parameter int         SIZE_W         = 16,
  parameter int         TIMEOUT_CYC    = 65535,
  localparam int        CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [7:0]                 cmd_addr,
  input  TCommandCode                cmd_code,
  input  logic [CH_W-1:0]            cmd_chan,
  input  logic                       cmd_done,
  input  logic [CHANNELS*SIZE_W-1:0] mem_used_ms,
  input  logic [CHANNELS*SIZE_W-1:0] mem_used_sm,
  output logic [7:0]                 resp_addr,
  output TCommandCode                resp_code,
  output logic [SIZE_W-1:0]          resp_size,
  output logic                       resp_en,
  output logic [CHANNELS-1:0]        spi_push_en,
  output logic [CH_W:0]              pop_sel,
  output logic [CHANNELS-1:0]        mil_push_en,
  output logic                       stat_rdy,
  output logic [SIZE_W-1:0]          stat_data,
  input  logic                       stat_pop,
  output logic                       reset_request
);

  THubState        state;
  logic [CH_W-1:0] chan;
  THubCfg          cfg;
  logic            accept;
  logic            busy;
  logic            timeout;

  assign resp_addr = SPI_BLOCK_ADDR;
  assign resp_en   = 1'b1;
  assign cfg       = hub_cfg(cmd_code);
  assign busy      = (state != HS_IDLE) && (state != HS_RESET);
  assign accept    = cmd_valid
                  && (cmd_addr == SPI_BLOCK_ADDR)
                  && ({1'b0, cmd_chan} < (CH_W+1)'(CHANNELS));

`ifdef MILSPI_TIMEOUT_EN
  logic [31:0] toCnt;

  assign timeout = busy && (toCnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || accept || !busy) toCnt <= '0;
    else                        toCnt <= toCnt + 32'd1;
  end
`else
  // Without the watchdog the limit can never be reached.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HS_IDLE;
      chan          <= '0;
      resp_code     <= TCC_UNKNOWN;
      resp_size     <= '0;
      spi_push_en   <= '0;
      pop_sel       <= '0;
      reset_request <= 1'b0;
    end else if (accept) begin
      state       <= cfg.state;
      chan        <= cmd_chan;
      resp_code   <= (cfg.state == HS_IDLE) ? TCC_UNKNOWN : cmd_code;
      spi_push_en <= cfg.spiPush ? (CHANNELS'(1) << cmd_chan) : '0;
      unique case (1'b1)
        cfg.popSts: begin
          pop_sel   <= {1'b1, {CH_W{1'b0}}};
          resp_size <= SIZE_W'(2 * CHANNELS);
        end
        cfg.popData: begin
          pop_sel   <= {1'b0, cmd_chan};
          resp_size <= mem_used_ms[cmd_chan*SIZE_W +: SIZE_W];
        end
        default: begin
          pop_sel   <= '0;
          resp_size <= '0;
        end
      endcase
      if (cfg.rstReq) reset_request <= 1'b1;
    end else if (cmd_done || timeout) begin
      state       <= HS_IDLE;
      resp_code   <= TCC_UNKNOWN;
      resp_size   <= '0;
      spi_push_en <= '0;
      pop_sel     <= '0;
    end
  end

  // Never drain a buffer towards MIL while SPI is filling it.
  always_comb begin
    mil_push_en = '0;
    for (int i = 0; i < CHANNELS; i++)
      mil_push_en[i] = (mem_used_sm[i*SIZE_W +: SIZE_W] != '0)
                    && !(state == HS_SEND && chan == CH_W'(i));
  end

  mil_spi_status_ser #(
    .CHANNELS(CHANNELS),
    .SIZE_W  (SIZE_W)
  ) uSer (
    .clk      (clk),
    .rst      (rst),
    .snap     (accept),
    .active   (state == HS_RECV_STS),
`ifdef MILSPI_TIMEOUT_EN
    .tsSet    (timeout),
`endif
    .memUsedMs(mem_used_ms),
    .memUsedSm(mem_used_sm),
    .statPop  (stat_pop),
    .statRdy  (stat_rdy),
    .statData (stat_data)
  );

endmodule

// File: tb/tb_mil_spi_hub.sv
// Self-checking bench for mil_spi_hub: directed cases then random traffic.
// Watchdog case runs only when MILSPI_TIMEOUT_EN is defined.
module tb_mil_spi_hub;
  import mil_spi_hub_pkg::*;

  localparam int CH = 2;
  localparam int SW = 16;
  localparam int CW = 1;
  localparam int TO = 10;
  localparam int NW = 2 * CH;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic [7:0]     cmd_addr;
  TCommandCode    cmd_code;
  logic [CW-1:0]  cmd_chan;
  logic           cmd_done;
  logic [CH*SW-1:0] memMs;
  logic [CH*SW-1:0] memSm;
  logic [7:0]     resp_addr;
  TCommandCode    resp_code;
  logic [SW-1:0]  resp_size;
  logic           resp_en;
  logic [CH-1:0]  spi_push_en;
  logic [CW:0]    pop_sel;
  logic [CH-1:0]  mil_push_en;
  logic           stat_rdy;
  logic [SW-1:0]  stat_data;
  logic           stat_pop;
  logic           reset_request;

  int nCmp = 0;
  int nErr = 0;

  // reference model state
  TCommandCode   mCode;
  logic [CW-1:0] mChan;
  logic [SW-1:0] mSize;
  logic          mRst;
  logic [SW-1:0] q[$];
  int            mCnt;

  always #5 clk = ~clk;

  mil_spi_hub #(
    .CHANNELS      (CH),
    .SPI_BLOCK_ADDR(8'hAB),
    .SIZE_W        (SW),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_addr     (cmd_addr),
    .cmd_code     (cmd_code),
    .cmd_chan     (cmd_chan),
    .cmd_done     (cmd_done),
    .mem_used_ms  (memMs),
    .mem_used_sm  (memSm),
    .resp_addr    (resp_addr),
    .resp_code    (resp_code),
    .resp_size    (resp_size),
    .resp_en      (resp_en),
    .spi_push_en  (spi_push_en),
    .pop_sel      (pop_sel),
    .mil_push_en  (mil_push_en),
    .stat_rdy     (stat_rdy),
    .stat_data    (stat_data),
    .stat_pop     (stat_pop),
    .reset_request(reset_request)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nErr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelEdge();
    bit acc;
    bit busy;
    acc  = cmd_valid && cmd_addr == 8'hAB && int'(cmd_chan) < CH;
    busy = mCode inside {TCC_SEND_DATA, TCC_RECEIVE_STS,
                         TCC_RECEIVE_DATA};
    if (rst) begin
      mCode = TCC_UNKNOWN;
      mChan = '0;
      mSize = '0;
      mRst  = 1'b0;
      mCnt  = 0;
      q.delete();
    end else if (acc) begin
      mChan = cmd_chan;
      mCnt  = 0;
      mSize = '0;
      q.delete();
      for (int i = 0; i < CH; i++) begin
        q.push_back(memMs[i*SW +: SW]);
        q.push_back(memSm[i*SW +: SW]);
      end
      case (cmd_code)
        TCC_SEND_DATA: mCode = TCC_SEND_DATA;
        TCC_RECEIVE_STS: begin
          mCode = TCC_RECEIVE_STS;
          mSize = SW'(NW);
        end
        TCC_RECEIVE_DATA: begin
          mCode = TCC_RECEIVE_DATA;
          mSize = memMs[cmd_chan*SW +: SW];
        end
        TCC_RESET: begin
          mCode = TCC_RESET;
          mRst  = 1'b1;
        end
        default: mCode = TCC_UNKNOWN;
      endcase
    end else if (cmd_done) begin
      mCode = TCC_UNKNOWN;
      mSize = '0;
    end else begin
      if (mCode == TCC_RECEIVE_STS && stat_pop && q.size() > 0)
        void'(q.pop_front());
`ifdef MILSPI_TIMEOUT_EN
      if (busy) begin
        mCnt++;
        if (mCnt == TO) begin
          mCode = TCC_UNKNOWN;
          mSize = '0;
        end
      end
`endif
    end
  endtask

  task automatic checkAll(input string tag);
    logic [CH-1:0] eSpi;
    logic [CH-1:0] eMil;
    logic [CW:0]   ePop;
    logic          eRdy;
    eSpi = (mCode == TCC_SEND_DATA) ? (CH'(1) << mChan) : '0;
    ePop = '0;
    if (mCode == TCC_RECEIVE_STS)  ePop = {1'b1, {CW{1'b0}}};
    if (mCode == TCC_RECEIVE_DATA) ePop = {1'b0, mChan};
    for (int i = 0; i < CH; i++)
      eMil[i] = (memSm[i*SW +: SW] != 0)
             && !(mCode == TCC_SEND_DATA && int'(mChan) == i);
    eRdy = (mCode == TCC_RECEIVE_STS) && (q.size() > 0);
    chk({tag, ".addr"}, 32'(resp_addr), 32'hAB);
    chk({tag, ".en"},   32'(resp_en), 32'd1);
    chk({tag, ".code"}, 32'(resp_code), 32'(mCode));
    chk({tag, ".size"}, 32'(resp_size), 32'(mSize));
    chk({tag, ".spi"},  32'(spi_push_en), 32'(eSpi));
    chk({tag, ".pop"},  32'(pop_sel), 32'(ePop));
    chk({tag, ".mil"},  32'(mil_push_en), 32'(eMil));
    chk({tag, ".rdy"},  32'(stat_rdy), 32'(eRdy));
    chk({tag, ".rreq"}, 32'(reset_request), 32'(mRst));
    if (eRdy) chk({tag, ".data"}, 32'(stat_data), 32'(q[0]));
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic cmd(input string tag, input logic [7:0] a,
                     input TCommandCode c, input logic [CW-1:0] ch);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_code  = c;
    cmd_chan  = ch;
    step(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic done(input string tag);
    cmd_done = 1'b1;
    step(tag);
    cmd_done = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] stsExp [NW];
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_code  = TCC_UNKNOWN;
    cmd_chan  = '0;
    cmd_done  = 1'b0;
    stat_pop  = 1'b0;
    memMs     = '0;
    memSm     = '0;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    step("idle");

    // SEND on channel 1 blocks its MIL drain
    memSm = {16'd5, 16'd4};
    cmd("t1", 8'hAB, TCC_SEND_DATA, 1'b1);
    chk("t1.spi1", 32'(spi_push_en), 32'b10);
    chk("t1.mil1", 32'(mil_push_en), 32'b01);
    done("t1.done");

    // foreign address is ignored
    cmd("t2", 8'hAC, TCC_SEND_DATA, 1'b0);
    chk("t2.spi0", 32'(spi_push_en), 32'b00);
    chk("t2.code", 32'(resp_code), 32'(TCC_UNKNOWN));

    // status stream order ms0,sm0,ms1,sm1
    memMs = {16'd7, 16'd3};
    memSm = {16'd0, 16'd9};
    stsExp = '{16'd3, 16'd9, 16'd7, 16'd0};
    cmd("t3", 8'hAB, TCC_RECEIVE_STS, 1'b0);
    chk("t3.size", 32'(resp_size), 32'd4);
    stat_pop = 1'b1;
    for (int k = 0; k < NW; k++) begin
      chk("t3.word", 32'(stat_data), 32'(stsExp[k]));
      step("t3.pop");
    end
    chk("t3.end", 32'(stat_rdy), 32'd0);
    step("t3.over");
    stat_pop = 1'b0;
    done("t3.done");

    // RECEIVE_DATA size is a snapshot
    memMs[15:0] = 16'd12;
    cmd("t4", 8'hAB, TCC_RECEIVE_DATA, 1'b0);
    memMs[15:0] = 16'd13;
    step("t4.hold");
    chk("t4.size", 32'(resp_size), 32'd12);
    done("t4.done");
    chk("t4.idle", 32'(resp_code), 32'(TCC_UNKNOWN));

    // sticky reset request
    cmd("t5", 8'hAB, TCC_RESET, 1'b0);
    done("t5.done");
    for (int k = 0; k < 3; k++) step("t5.wait");
    chk("t5.stk", 32'(reset_request), 32'd1);
    rst = 1'b1;
    step("t5.rst");
    rst = 1'b0;
    chk("t5.clr", 32'(reset_request), 32'd0);

`ifdef MILSPI_TIMEOUT_EN
    cmd("t6", 8'hAB, TCC_SEND_DATA, 1'b0);
    for (int k = 0; k < TO; k++) step("t6.wait");
    chk("t6.idle", 32'(resp_code), 32'(TCC_UNKNOWN));
    chk("t6.ts", 32'(stat_data[15]), 32'd1);
    cmd("t6.re", 8'hAB, TCC_RECEIVE_STS, 1'b0);
    chk("t6.tsclr", 32'(stat_data[15]), 32'(memMs[15]));
    done("t6.done");
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hAB;
      cmd_code  = TCommandCode'($urandom_range(0, 7));
      cmd_chan  = CW'($urandom);
      cmd_done  = ($urandom_range(0, 9) == 0);
      stat_pop  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < CH; i++) begin
          memMs[i*SW +: SW] = ($urandom_range(0, 3) == 0)
                            ? 16'd0 : 16'($urandom);
          memSm[i*SW +: SW] = ($urandom_range(0, 3) == 0)
                            ? 16'd0 : 16'($urandom);
        end
      end
      step("rnd");
    end

    // reset in the middle of a command
    cmd_done = 1'b0;
    stat_pop = 1'b0;
    cmd("mid", 8'hAB, TCC_RECEIVE_STS, 1'b1);
    rst = 1'b1;
    step("mid.rst");
    rst = 1'b0;
    chk("mid.data", 32'(stat_data), 32'd0);
    step("mid.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
